// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared types and constants for the two-port SRAM arbiter.
// Holds the FSM state encoding, the default bus widths and the port-select
// encoding used by sram_arbiter and its grant selector sram_arb_rr.
package sram_arb_pkg;

    localparam int SRAM_ADDR_W = 18;
    localparam int SRAM_DATA_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_BUSY  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_ACK   = 3'd4
    } arb_state_e;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

    // The port that did not win last time; used for alternating contention.
    function automatic port_e other_port(input port_e p);
        return (p == PORT_A) ? PORT_B : PORT_A;
    endfunction

endpackage

// File: rtl/sram_arb_rr.sv
// sram_arb_rr: two-input grant selection for sram_arbiter.
// With SRAM_ARB_RR_EN defined, contention goes to the port that was not
// granted last (last-grant resets to B so A wins the first contention).
// Without it, A always wins contention and no last-grant state exists.
module sram_arb_rr
    import sram_arb_pkg::*;
(
    input  logic  clk,
    input  logic  reset_n,
    input  logic  a_req_i,
    input  logic  b_req_i,
    input  logic  upd_i,       // a transaction is being acknowledged this cycle
    input  port_e upd_port_i,  // port that transaction belonged to
    output logic  valid_o,
    output port_e port_o
);

    assign valid_o = a_req_i | b_req_i;

`ifdef SRAM_ARB_RR_EN
    port_e last_q;

    // Remember which port was served most recently.
    // NOTE: flops take non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q <= PORT_B;
        end else if (upd_i) begin
            last_q <= upd_port_i;
        end
    end

    // Single requester wins outright; under contention the other port wins.
    always_comb begin
        port_o = PORT_A;
        if (a_req_i && b_req_i) begin
            port_o = other_port(last_q);
        end else if (b_req_i) begin
            port_o = PORT_B;
        end
    end
`else
    // Fixed priority needs no history; these inputs are intentionally unused.
    logic unused_rr;
    assign unused_rr = ^{clk, reset_n, upd_i, upd_port_i};

    // A wins whenever it requests; B only when A is idle.
    always_comb begin
        port_o = (!a_req_i && b_req_i) ? PORT_B : PORT_A;
    end
`endif

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one sram controller between two requesters.
// Grants one port at a time, issues a one-cycle read/write pulse, waits for
// the controller's ready to drop and return, then acks the granted port.
// Optional macro SRAM_ARB_RR_EN selects round-robin contention handling
// (default build: fixed priority, port A wins).
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W = SRAM_ADDR_W,
    parameter int DATA_W = SRAM_DATA_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_write,
    output logic              mem_read,
    output logic              mem_write,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_data_read
);

    arb_state_e        state_q, state_d;
    port_e             grant_q, grant_d;
    logic              op_we_q, op_we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
    logic [DATA_W-1:0] b_rdata_q, b_rdata_d;
    logic              sel_valid;
    port_e             sel_port;

    sram_arb_rr u_rr (
        .clk        (clk),
        .reset_n    (reset_n),
        .a_req_i    (a_req),
        .b_req_i    (b_req),
        .upd_i      (state_q == ST_ACK),
        .upd_port_i (grant_q),
        .valid_o    (sel_valid),
        .port_o     (sel_port)
    );

    // Transaction sequencing and latching of the granted command.
    always_comb begin
        // NOTE: every _d starts at its held value so no path leaves it unassigned (no latches).
        state_d   = state_q;
        grant_d   = grant_q;
        op_we_d   = op_we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;
        case (state_q)
            ST_IDLE: begin
                // Command fields are taken at grant; later changes are ignored.
                if (mem_ready && sel_valid) begin
                    grant_d = sel_port;
                    if (sel_port == PORT_A) begin
                        op_we_d = a_we;
                        addr_d  = a_addr;
                        wdata_d = a_wdata;
                    end else begin
                        op_we_d = b_we;
                        addr_d  = b_addr;
                        wdata_d = b_wdata;
                    end
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_BUSY;
            ST_BUSY: begin
                if (!mem_ready) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (mem_ready) begin
                    if (!op_we_q) begin
                        if (grant_q == PORT_A) a_rdata_d = mem_data_read;
                        else                   b_rdata_d = mem_data_read;
                    end
                    state_d = ST_ACK;
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State, latched command and per-port read data registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            grant_q   <= PORT_A;
            op_we_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            op_we_q   <= op_we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
        end
    end

    assign mem_address    = addr_q;
    assign mem_data_write = wdata_q;
    assign mem_write      = (state_q == ST_ISSUE) &&  op_we_q;
    assign mem_read       = (state_q == ST_ISSUE) && !op_we_q;
    assign a_ack          = (state_q == ST_ACK) && (grant_q == PORT_A);
    assign b_ack          = (state_q == ST_ACK) && (grant_q == PORT_B);
    assign a_rdata        = a_rdata_q;
    assign b_rdata        = b_rdata_q;

endmodule
